// File: rtl/th_array_hyst.sv
// Array of weighted threshold gates with hysteresis, plus a ko acknowledge FSM
// that counts completed DATA->NULL wavefronts and flags data arriving during a NULL request.
module th_array_hyst #(
  parameter int          N_IN      = 4,
  parameter int          THRESH    = 2,
  parameter logic [31:0] WEIGHTS   = 32'h0000_2111,
  parameter int          CHANNELS  = 1,
  parameter int          RESET_VAL = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS*N_IN-1:0] x,
  output logic [CHANNELS-1:0]      y,
  output logic                     all_data,
  output logic                     all_null,
  output logic                     ko,
  output logic [7:0]               wave_cnt,
  output logic                     hyst_err
);

  function automatic int weight_sum(input logic [31:0] w, input int n);
    int s;
    s = 0;
    for (int i = 0; i < n && i < 8; i++) s += int'(w[4*i +: 4]);
    return s;
  endfunction

  function automatic bit weights_ok(input logic [31:0] w, input int n);
    for (int i = 0; i < n && i < 8; i++)
      if (w[4*i +: 4] == 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  localparam int   WSUM = weight_sum(WEIGHTS, N_IN);
  localparam int   SW   = $clog2(WSUM + 1);
  localparam logic RV   = (RESET_VAL != 0);

  if (N_IN < 2 || N_IN > 8) begin : g_bad_n_in
    $error("th_array_hyst: N_IN must be in 2..8");
  end
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("th_array_hyst: CHANNELS must be in 1..32");
  end
  if (!weights_ok(WEIGHTS, N_IN)) begin : g_bad_weights
    $error("th_array_hyst: every active weight must be in 1..15");
  end
  if (THRESH < 1 || THRESH > WSUM) begin : g_bad_thresh
    $error("th_array_hyst: THRESH must be in 1..sum of weights");
  end
  if (RESET_VAL < 0 || RESET_VAL > 1) begin : g_bad_reset_val
    $error("th_array_hyst: RESET_VAL must be 0 or 1");
  end

  // ko handshake: ko=1 requests DATA; the gates answer with all_data, which
  // flips ko to 0 (request NULL); all_null then flips it back and closes a wavefront.
  typedef enum logic {ST_RFN = 1'b0, ST_RFD = 1'b1} ko_state_t;
  localparam ko_state_t ST_RESET = RV ? ST_RFN : ST_RFD;

  ko_state_t             state_q, state_d;
  logic                  wave_inc;
  logic [CHANNELS-1:0]   y_next;
  logic                  data_rise;

  always_comb begin
    y_next = y;
    for (int c = 0; c < CHANNELS; c++) begin
      logic [SW-1:0] acc;
      acc = '0;
      for (int i = 0; i < N_IN; i++)
        if (x[c*N_IN + i]) acc = acc + SW'(WEIGHTS[4*i +: 4]);
      // Below threshold but not fully null: the gate keeps its previous value.
      if (acc >= SW'(THRESH))
        y_next[c] = 1'b1;
      else if (x[c*N_IN +: N_IN] == '0)
        y_next[c] = 1'b0;
      else
        y_next[c] = y[c];
    end
  end

  assign all_data = &y;
  assign all_null = ~|y;

  always_comb begin
    state_d  = state_q;
    wave_inc = 1'b0;
    ko       = (state_q == ST_RFD);
    case (state_q)
      ST_RFD: if (all_data) state_d = ST_RFN;
      ST_RFN: if (all_null) begin
        state_d  = ST_RFD;
        wave_inc = 1'b1;
      end
      default: state_d = ST_RESET;
    endcase
  end

  assign data_rise = (|(y_next & ~y)) && !ko;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y        <= {CHANNELS{RV}};
      state_q  <= ST_RESET;
      wave_cnt <= 8'd0;
      hyst_err <= 1'b0;
    end else begin
      y       <= y_next;
      state_q <= state_d;
      if (wave_inc && wave_cnt != 8'hFF) wave_cnt <= wave_cnt + 8'd1;
      if (data_rise) hyst_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_th_array_hyst.sv
// Bench for th_array_hyst: three instances (default, 4 channels, reset-to-DATA)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_th_array_hyst;

  logic        clk;
  logic        rst;
  logic [3:0]  x0, x2;
  logic [15:0] x1;
  logic [0:0]  y0, y2;
  logic [3:0]  y1;
  logic        ad0, an0, ko0, er0;
  logic        ad1, an1, ko1, er1;
  logic        ad2, an2, ko2, er2;
  logic [7:0]  wc0, wc1, wc2;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  th_array_hyst u_d0 (
    .clk(clk), .rst(rst), .x(x0), .y(y0), .all_data(ad0), .all_null(an0),
    .ko(ko0), .wave_cnt(wc0), .hyst_err(er0)
  );
  th_array_hyst #(.CHANNELS(4)) u_d1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .all_data(ad1), .all_null(an1),
    .ko(ko1), .wave_cnt(wc1), .hyst_err(er1)
  );
  th_array_hyst #(.RESET_VAL(1)) u_d2 (
    .clk(clk), .rst(rst), .x(x2), .y(y2), .all_data(ad2), .all_null(an2),
    .ko(ko2), .wave_cnt(wc2), .hyst_err(er2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: weights of inputs 0..3 are 1,1,1,2; threshold 2
  int w[4]   = '{1, 1, 1, 2};
  int nch[3] = '{1, 4, 1};
  int rv[3]  = '{0, 0, 1};
  int m_y[3], m_ko[3], m_wc[3], m_err[3];

  function automatic int full_mask(input int d);
    return (1 << nch[d]) - 1;
  endfunction

  function automatic logic [15:0] get_x(input int d);
    case (d)
      0:       return {12'd0, x0};
      1:       return x1;
      default: return {12'd0, x2};
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_y[d]   <= rv[d] ? full_mask(d) : 0;
        m_ko[d]  <= rv[d] ? 0 : 1;
        m_wc[d]  <= 0;
        m_err[d] <= 0;
      end else begin
        logic [15:0] xv;
        int ny, oy, nib, s;
        xv = get_x(d);
        oy = m_y[d];
        ny = 0;
        for (int c = 0; c < nch[d]; c++) begin
          nib = (xv >> (4*c)) & 15;
          s = 0;
          for (int i = 0; i < 4; i++) if ((nib >> i) & 1) s += w[i];
          if (s >= 2) ny |= (1 << c);
          else if (nib != 0) ny |= oy & (1 << c);
        end
        m_y[d] <= ny;
        if (m_ko[d] == 1 && oy == full_mask(d)) m_ko[d] <= 0;
        if (m_ko[d] == 0 && oy == 0) begin
          m_ko[d] <= 1;
          m_wc[d] <= (m_wc[d] < 255) ? m_wc[d] + 1 : 255;
        end
        if (m_ko[d] == 0 && (ny & ~oy) != 0) m_err[d] <= 1;
      end
    end
  end

  // scoreboard compare, every cycle on the falling edge
  task automatic check_dut(input int d, input logic [3:0] yv, input logic adv,
                           input logic anv, input logic kov, input logic [7:0] wcv,
                           input logic erv);
    chk($sformatf("d%0d_y", d),        yv,  m_y[d]);
    chk($sformatf("d%0d_all_data", d), adv, (m_y[d] == full_mask(d)) ? 1 : 0);
    chk($sformatf("d%0d_all_null", d), anv, (m_y[d] == 0) ? 1 : 0);
    chk($sformatf("d%0d_ko", d),       kov, m_ko[d]);
    chk($sformatf("d%0d_wave_cnt", d), wcv, m_wc[d]);
    chk($sformatf("d%0d_hyst_err", d), erv, m_err[d]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, {3'd0, y0}, ad0, an0, ko0, wc0, er0);
      check_dut(1, y1,         ad1, an1, ko1, wc1, er1);
      check_dut(2, {3'd0, y2}, ad2, an2, ko2, wc2, er2);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [3:0] rand_nib();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 4'h0;
    if (r == 1) return 4'hF;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    rst = 1'b1;
    x0 = '0; x1 = '0; x2 = '0;
    tick(2);
    chk_en = 1;
    chk("rst_y0", y0, 0);   chk("rst_ko0", ko0, 1);
    chk("rst_wc0", wc0, 0); chk("rst_err0", er0, 0);
    chk("rst_y1", y1, 0);   chk("rst_ko1", ko1, 1);
    chk("rst_y2", y2, 1);   chk("rst_ko2", ko2, 0);
    chk("rst_ad2", ad2, 1);
    rst = 1'b0;

    // reset-to-DATA instance: release into x=0
    tick(1);
    chk("rv1_y_null", y2, 0); chk("rv1_ko_still_rfn", ko2, 0);
    chk("rv1_wc_no_inc_on_release", wc2, 0);
    tick(1);
    chk("rv1_ko_rfd", ko2, 1); chk("rv1_wc1", wc2, 1);
    x2 = 4'b1000; tick(1); chk("rv1_y_data", y2, 1);
    tick(1); chk("rv1_ko_rfn", ko2, 0);
    x2 = 4'b0000; tick(1); chk("rv1_y_null2", y2, 0); chk("rv1_ko_rfn2", ko2, 0);
    x2 = 4'b1000; tick(1); chk("rv1_err_set", er2, 1);
    x2 = 4'b0000; tick(3); chk("rv1_err_sticky", er2, 1);

    // single gate: light input stays low, heavy input fires
    x0 = 4'b0001; tick(3); chk("light_y0", y0, 0);
    x0 = 4'b1000; tick(1);
    chk("heavy_y0", y0, 1); chk("heavy_ad0", ad0, 1); chk("heavy_ko_lag", ko0, 1);
    tick(1); chk("heavy_ko0", ko0, 0);

    // hysteresis hold then null
    x0 = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      tick(1); chk("hyst_hold_y0", y0, 1);
    end
    x0 = 4'b0000; tick(1);
    chk("hyst_null_y0", y0, 0); chk("hyst_wc_before", wc0, 0);
    tick(1); chk("hyst_ko0", ko0, 1); chk("hyst_wc_after", wc0, 1);

    // threshold reached from light inputs
    x0 = 4'b0011; tick(1); chk("light2_y0", y0, 1);
    x0 = 4'b0000; tick(2); chk("light2_wc", wc0, 2);
    x0 = 4'b0110; tick(1); chk("light3_y0", y0, 1);
    x0 = 4'b0000; tick(2); chk("light3_wc", wc0, 3); chk("clean_err0", er0, 0);

    // four channels: completion needs every channel
    x1 = 16'h0888; tick(3); chk("ch3_missing_ko", ko1, 1); chk("ch3_missing_ad", ad1, 0);
    x1 = 16'h8888; tick(1); chk("all_ch_ad", ad1, 1);
    tick(1); chk("all_ch_ko", ko1, 0);
    x1 = 16'h8000; tick(3); chk("part_null_ko", ko1, 0); chk("part_null_wc", wc1, 0);
    chk("part_null_y", y1, 4'b1000);
    x1 = 16'h0000; tick(2); chk("all_null_ko", ko1, 1); chk("all_null_wc", wc1, 1);
    chk("mc_err_clear", er1, 0);
    x1 = 16'h8888; tick(2);
    x1 = 16'h8000; tick(1); chk("mc_rfn_ko", ko1, 0);
    x1 = 16'h8008; tick(1); chk("mc_err_set", er1, 1);
    x1 = 16'h0000; tick(3);

    // randomized phase
    for (int k = 0; k < 500; k++) begin
      x0 = rand_nib();
      x2 = rand_nib();
      for (int c = 0; c < 4; c++) x1[4*c +: 4] = rand_nib();
      tick($urandom_range(1, 3));
    end

    // saturation of the wavefront counter
    x0 = '0; x1 = '0; x2 = '0;
    tick(3);
    for (int k = 0; k < 300; k++) begin
      x0 = 4'b1000; tick(2);
      x0 = 4'b0000; tick(2);
    end
    chk("sat_wc0", wc0, 255);
    for (int k = 0; k < 5; k++) begin
      x0 = 4'b1000; tick(2);
      x0 = 4'b0000; tick(2);
    end
    chk("sat_hold_wc0", wc0, 255);

    // asynchronous reset in the middle of a cycle
    x0 = 4'b1000; x2 = 4'b1000;
    tick(1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_y0", y0, 0);   chk("async_ko0", ko0, 1);
    chk("async_wc0", wc0, 0); chk("async_err0", er0, 0);
    chk("async_y1", y1, 0);   chk("async_ko1", ko1, 1);
    chk("async_err1", er1, 0); chk("async_wc1", wc1, 0);
    chk("async_y2", y2, 1);   chk("async_ko2", ko2, 0);
    chk("async_err2", er2, 0);
    x2 = 4'b0000;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("post_rst_y0", y0, 1); chk("post_rst_wc0", wc0, 0);
    chk("post_rst_err0", er0, 0); chk("post_rst_y2", y2, 0);
    chk("post_rst_err2", er2, 0);
    tick(1);
    chk("post_rst_ko0", ko0, 0); chk("post_rst_ko2", ko2, 1);
    chk("post_rst_wc2", wc2, 1);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/th_array_hyst.md
TH_ARRAY_HYST -- requirements
Module: th_array_hyst

Interface
REQ-001 Parameter N_IN, default 4: inputs per gate, legal range 2..8.
REQ-002 Parameter THRESH, default 2: threshold M, legal range 1..sum of weights.
REQ-003 Parameter WEIGHTS, default 16'h2111: packed 4-bit weight per input; input i uses bits [4i+3:4i]; legal range 1..15.
REQ-004 Parameter CHANNELS, default 1: number of independent gates, legal range 1..32.
REQ-005 Parameter RESET_VAL, default 0: per-gate output value during reset (0 = reset-to-NULL, 1 = reset-to-DATA).
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 x  input  CHANNELS*N_IN  gate inputs; channel c uses bits [c*N_IN +: N_IN].
REQ-009 y  output  CHANNELS  registered gate outputs.
REQ-010 all_data  output  1  high when every y bit is 1.
REQ-011 all_null  output  1  high when every y bit is 0.
REQ-012 ko  output  1  registered acknowledge; 1 = request-for-data, 0 = request-for-null.
REQ-013 wave_cnt  output  8  saturating count of completed DATA-to-NULL wavefronts.
REQ-014 hyst_err  output  1  sticky flag for a gate that asserted illegally; see REQ-021.

Function
REQ-015 Per channel, S = sum of WEIGHTS[i] over asserted inputs x[i]; S width = clog2(sum of weights + 1), with no overflow.
REQ-016 Per channel, each clock: if S >= THRESH, y <= 1; else if all N_IN inputs are 0, y <= 0; else y holds its value (hysteresis).
REQ-017 Latency is 1 clock from an input change to the y update; y has no combinational path from x.
REQ-018 all_data and all_null are combinational from registered y; with CHANNELS=1 they equal y and ~y.
REQ-019 ko state machine with states RFD (ko=1) and RFN (ko=0): RFD -> RFN on the clock where all_data=1; RFN -> RFD on the clock where all_null=1; otherwise hold.
REQ-020 On each RFN -> RFD transition, wave_cnt increments by 1 and saturates at 255 (no wrap).
REQ-021 hyst_err is set when any y bit transitions 0->1 while ko=0, i.e. DATA arrives during a NULL request. It stays set until reset.
REQ-022 When all_data and all_null are both satisfiable (no state), the present ko state decides the transition. With CHANNELS>=1 both cannot be high together.
REQ-023 Parameter values outside their legal ranges shall fail elaboration.

Reset
REQ-024 While rst=1, regardless of clk: every y bit = RESET_VAL, ko = ~RESET_VAL (RFD if RESET_VAL=0, RFN if 1), wave_cnt = 0, hyst_err = 0.
REQ-025 When rst is asserted mid-wavefront, all state clears immediately without waiting for a clock. On the first clock after deassertion, REQ-016 applies to the current x.
REQ-026 Reset deassertion shall not itself increment wave_cnt or set hyst_err.

Verification
REQ-027 Use defaults (th24w2 equivalent). Apply x=4'b0001 (input 0 only, weight 1): y stays 0. Apply x=4'b1000 (weight 2): y=1 after 1 clock and all_data=1; ko=0 on the following clock.
REQ-028 Hysteresis: from y=1, apply x=4'b0010. y must hold 1 for 5 clocks. Then apply x=0: y=0 next clock, ko=1 the clock after, and wave_cnt goes 0 -> 1.
REQ-029 Threshold from light inputs: x=4'b0011 gives S=2 and y=1; x=4'b0110 also gives y=1.
REQ-030 Use CHANNELS=4. Drive DATA on channels 0-2 only: ko stays 1. Drive channel 3: ko=0. Null channels 0-2 only: ko stays 0, wave_cnt is unchanged. Null all channels: ko=1 and wave_cnt increments.
REQ-031 Run 300 complete wavefronts: wave_cnt reads 255 and stays 255. Then assert rst asynchronously mid-cycle: all outputs reach their reset values before the next clk edge.
REQ-032 Use RESET_VAL=1. During rst, y=1 and ko=0. After release, drive x=0: y=0, ko=1, wave_cnt=1. Then drive DATA while ko=0 in a second run: hyst_err=1 and it stays 1.
